rr_grant_ctrl: RTL and testbench
================================

Name: rr_grant_ctrl

Overview:
- Round-robin arbiter/sequencer that shares one demux-steered resource (e.g. a write port fanned out via demux4/demux8) between N requesters.
- Picks one requester and drives the encoded select plus enable that feed the demux `sel`/`en` inputs.
- Holds the grant until the owner signals done, drops its request, or a hold timeout fires.
- Sits between requesting units (bus masters, writeback sources) and the demux.

Parameters:
- N, 4, number of requesters; power of two, 2..8.
- SELW, 2, select width; must equal log2(N).
- MAX_HOLD, 15, maximum BUSY cycles before forced release; 1..255.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester request, level-sensitive.
- done  input  1  current owner finished; sampled only in BUSY.
- grant  output  N  one-hot grant, registered; all-zero when idle.
- sel  output  SELW  binary index of the granted requester; feeds demux sel.
- en  output  1  grant valid; feeds demux en; equals |grant.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, grant=0, sel=0, en=0, timeout=0, ptr=0, hold_cnt=0.
  - Takes effect immediately, including mid-grant; the grant is lost with no timeout pulse.
- All outputs are registered; no combinational path from inputs to outputs.
- State machine, two states, IDLE and BUSY:
  - IDLE, req==0: stay IDLE; outputs stay 0.
  - IDLE, req!=0: winner = first set bit of req searching ptr, ptr+1, ..., wrapping modulo N. On the next edge: grant=onehot(winner), sel=winner, en=1, hold_cnt=0, state=BUSY.
  - Latency is one cycle from req sampled high to grant high.
  - BUSY, each cycle: grant/sel/en held constant; hold_cnt increments, saturating at MAX_HOLD.
  - BUSY release conditions, in priority order, evaluated on the same sampled cycle:
    1. done=1: normal release.
    2. req[sel]=0: abort release; the owner withdrew.
    3. hold_cnt==MAX_HOLD-1 and neither of the above: forced release, timeout=1 for the next cycle only.
  - On any release edge: grant=0, en=0, sel keeps its last value, ptr=(sel+1) mod N (wrap at N-1 → 0), state=IDLE.
- Mandatory dead cycle: after release, at least one cycle with en=0 precedes the next grant. This guarantees the demux output fully deasserts between owners.
- Fairness: a requester holding req continuously is granted within N grants. The last owner has lowest priority next arbitration.
- Simultaneous events:
  - done and timeout threshold in the same cycle: done wins, no timeout pulse.
  - done and req[sel] drop together: normal release.
  - Requests from other requesters while BUSY are ignored until IDLE.
  - done asserted in IDLE is ignored.
- Width rules:
  - ptr and sel are SELW bits; wrap is natural modulo 2^SELW since N=2^SELW.
  - hold_cnt width is 8 bits.
- timeout is 0 on every cycle other than the one following a forced release.

Test Plan:
- Reset then req=0000 for 10 cycles → grant=0000, en=0, sel=0, timeout=0 throughout.
- req=0100 at cycle 0, done pulse at cycle 3 → grant=0100, sel=2, en=1 from cycle 1. Release visible at cycle 4 (grant=0000). Next ptr=3.
- req=1111 held, done pulsed 1 cycle after each grant → grant sequence 0001, 0010, 0100, 1000, 0001. Each grant is separated by exactly one en=0 cycle.
- Fairness and wrap:
  - ptr=3 (after granting requester 2), req=0101 → requester 0 granted, since the search wraps 3→0.
  - Then with req=0101 still set, requester 2 is granted next.
- req=0010, no done, MAX_HOLD=15 → en high for exactly 15 cycles, then grant=0000 with timeout=1 for one cycle. Requester 1 is then re-granted after the dead cycle, since it is the sole requester.
- Mid-operation events:
  - BUSY on requester 3, assert rst_n=0 mid-cycle → grant/en/sel clear immediately (asynchronously). After release of reset with req=1000, grant=1000 one cycle later.
  - Separately: done and hold_cnt=MAX_HOLD-1 coincide → no timeout pulse.

Source files
------------

// File: rtl/rr_grant_ctrl_if.sv
// Arbitration bus between the requesting units and rr_grant_ctrl.
//   req     : per-requester level request (requesters -> arbiter)
//   done    : current owner finished (requesters -> arbiter)
//   grant   : one-hot registered grant (arbiter -> requesters)
//   sel     : binary index of the owner, feeds demux sel
//   en      : grant valid, feeds demux en
//   timeout : one-cycle pulse after a forced release
interface rr_grant_ctrl_if #(
    parameter int N    = 4,
    parameter int SELW = 2
);
    logic [N-1:0]    req;
    logic            done;
    logic [N-1:0]    grant;
    logic [SELW-1:0] sel;
    logic            en;
    logic            timeout;

    modport master (
        output req, done,
        input  grant, sel, en, timeout
    );

    modport slave (
        input  req, done,
        output grant, sel, en, timeout
    );
endinterface

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller sharing one demux-steered resource
// between N requesters. Holds the grant until done, request withdrawal
// or a hold timeout, then forces one idle cycle before the next grant.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rr_grant_ctrl_if.slave (req/done in; grant/sel/en/timeout out)
// Parameters: N (power of two, 2..8), SELW = log2(N), MAX_HOLD (1..255).
module rr_grant_ctrl #(
    parameter int N        = 4,
    parameter int SELW     = 2,
    parameter int MAX_HOLD = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_grant_ctrl_if.slave bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);

    state_t          state_q, state_n;
    logic [N-1:0]    grant_q, grant_n;
    logic [SELW-1:0] sel_q, sel_n;
    logic [SELW-1:0] ptr_q, ptr_n;
    logic            en_q, en_n;
    logic            to_q, to_n;
    logic [7:0]      cnt_q, cnt_n;

    logic            found;
    logic [SELW-1:0] win;
    logic            rel_done;
    logic            rel_abort;
    logic            rel_force;

    // Rotating priority search starting at ptr; SELW-bit addition wraps
    // modulo N because N is a power of two.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && bus.req[ptr_q + SELW'(i)]) begin
                found = 1'b1;
                win   = ptr_q + SELW'(i);
            end
        end
    end

    assign rel_done  = bus.done;
    assign rel_abort = !bus.req[sel_q];
    assign rel_force = (cnt_q == HOLD_LAST);

    always_comb begin
        state_n = state_q;
        grant_n = grant_q;
        sel_n   = sel_q;
        ptr_n   = ptr_q;
        en_n    = en_q;
        to_n    = 1'b0;
        cnt_n   = cnt_q;

        unique case (state_q)
            IDLE: begin
                grant_n = '0;
                en_n    = 1'b0;
                if (found) begin
                    grant_n      = '0;
                    grant_n[win] = 1'b1;
                    sel_n        = win;
                    en_n         = 1'b1;
                    cnt_n        = '0;
                    state_n      = BUSY;
                end
            end
            BUSY: begin
                if (rel_done || rel_abort || rel_force) begin
                    // Timeout only when neither done nor withdrawal caused it.
                    to_n    = !rel_done && !rel_abort;
                    grant_n = '0;
                    en_n    = 1'b0;
                    ptr_n   = sel_q + 1'b1;
                    state_n = IDLE;
                end else if (cnt_q != HOLD_MAX) begin
                    cnt_n = cnt_q + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            en_q    <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            grant_q <= grant_n;
            sel_q   <= sel_n;
            ptr_q   <= ptr_n;
            en_q    <= en_n;
            to_q    <= to_n;
            cnt_q   <= cnt_n;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.sel     = sel_q;
    assign bus.en      = en_q;
    assign bus.timeout = to_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
module tb_rr_grant_ctrl;

    localparam int N        = 4;
    localparam int SELW     = 2;
    localparam int MAX_HOLD = 15;

    typedef struct {
        int grant;
        int sel;
        int en;
        int to;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rr_grant_ctrl_if #(.N(N), .SELW(SELW)) bus ();

    rr_grant_ctrl #(
        .N(N),
        .SELW(SELW),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    // Reference model state: owner index valid while m_busy.
    bit m_busy;
    int m_sel;
    int m_ptr;
    int m_cnt;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_sel  = 0;
        m_ptr  = 0;
        m_cnt  = 0;
    endtask

    // Advance the model by one clock given the inputs sampled this cycle.
    task automatic model_cycle(input logic [N-1:0] r, input logic d, output exp_t e);
        int to;
        to = 0;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (r[idx]) begin
                    m_busy = 1'b1;
                    m_sel  = idx;
                    m_cnt  = 0;
                    break;
                end
            end
        end else begin
            if (d || !r[m_sel] || m_cnt == MAX_HOLD - 1) begin
                to     = (!d && r[m_sel]) ? 1 : 0;
                m_busy = 1'b0;
                m_ptr  = (m_sel + 1) % N;
            end else begin
                m_cnt++;
            end
        end
        e.grant = m_busy ? (1 << m_sel) : 0;
        e.sel   = m_sel;
        e.en    = m_busy ? 1 : 0;
        e.to    = to;
    endtask

    // Drive one cycle of stimulus (called just after a rising edge),
    // queue the expectation, then compare just after the next edge.
    task automatic step(input logic [N-1:0] r, input logic d);
        exp_t e;
        bus.req  = r;
        bus.done = d;
        model_cycle(r, d, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check_eq("grant", int'(bus.grant), e.grant);
            check_eq("sel", int'(bus.sel), e.sel);
            check_eq("en", int'(bus.en), e.en);
            check_eq("timeout", int'(bus.timeout), e.to);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int exp_seq[5] = '{1, 2, 4, 8, 1};
    int en_cycles;

    initial begin
        bus.req  = '0;
        bus.done = 1'b0;
        model_reset();

        // Reset state
        @(posedge clk);
        #1;
        check_eq("rst_grant", int'(bus.grant), 0);
        check_eq("rst_sel", int'(bus.sel), 0);
        check_eq("rst_en", int'(bus.en), 0);
        check_eq("rst_timeout", int'(bus.timeout), 0);
        rst_n = 1'b1;

        // Idle with no requests
        for (int i = 0; i < 10; i++) step(4'b0000, 1'b0);

        // Single requester 2, done at third busy cycle
        step(4'b0100, 1'b0);
        check_eq("r2_grant", int'(bus.grant), 4);
        check_eq("r2_sel", int'(bus.sel), 2);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b1);
        check_eq("r2_release", int'(bus.grant), 0);

        // ptr=3, req=0101: search wraps to requester 0, then 2
        step(4'b0101, 1'b0);
        check_eq("wrap_g0", int'(bus.grant), 1);
        step(4'b0101, 1'b1);
        step(4'b0101, 1'b0);
        check_eq("wrap_g2", int'(bus.grant), 4);
        step(4'b0101, 1'b1);

        // Full rotation with all requesters active
        pulse_reset();
        for (int g = 0; g < 5; g++) begin
            step(4'b1111, 1'b0);
            check_eq("rr_seq", int'(bus.grant), exp_seq[g]);
            step(4'b1111, 1'b1);
            check_eq("rr_dead", int'(bus.en), 0);
        end
        step(4'b0000, 1'b0);

        // Forced release after MAX_HOLD cycles, then re-grant
        en_cycles = 0;
        step(4'b0010, 1'b0);
        for (int i = 0; i < 40 && bus.en; i++) begin
            en_cycles++;
            step(4'b0010, 1'b0);
        end
        check_eq("hold_len", en_cycles, MAX_HOLD);
        check_eq("to_pulse", int'(bus.timeout), 1);
        check_eq("to_grant", int'(bus.grant), 0);
        step(4'b0010, 1'b0);
        check_eq("regrant", int'(bus.grant), 2);
        check_eq("to_clear", int'(bus.timeout), 0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        // done coincides with hold threshold: no timeout
        step(4'b0010, 1'b0);
        for (int i = 0; i < MAX_HOLD - 1; i++) step(4'b0010, 1'b0);
        step(4'b0010, 1'b1);
        check_eq("done_wins_en", int'(bus.en), 0);
        check_eq("done_wins_to", int'(bus.timeout), 0);
        step(4'b0000, 1'b0);

        // Asynchronous reset while requester 3 owns the grant
        step(4'b1000, 1'b0);
        check_eq("r3_grant", int'(bus.grant), 8);
        step(4'b1000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_grant", int'(bus.grant), 0);
        check_eq("arst_en", int'(bus.en), 0);
        check_eq("arst_sel", int'(bus.sel), 0);
        check_eq("arst_timeout", int'(bus.timeout), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b1000, 1'b0);
        check_eq("post_rst_grant", int'(bus.grant), 8);
        step(4'b1000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
